// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster timing defaults and register map for the VGA sync peripheral.
// The default set is 640x480@60 with a pixel rate of clk/2 from a 50 MHz clock.
package vga_timing_pkg;

    localparam logic [9:0] DEF_H_ACTIVE = 10'd640;
    localparam logic [9:0] DEF_H_FP     = 10'd16;
    localparam logic [9:0] DEF_H_SYNC   = 10'd96;
    localparam logic [9:0] DEF_H_BP     = 10'd48;

    localparam logic [9:0] DEF_V_ACTIVE = 10'd480;
    localparam logic [9:0] DEF_V_FP     = 10'd10;
    localparam logic [9:0] DEF_V_SYNC   = 10'd2;
    localparam logic [9:0] DEF_V_BP     = 10'd33;

    typedef enum logic [1:0] {
        CTRL    = 2'd0,
        LINE_LO = 2'd1,
        LINE_HI = 2'd2,
        STATUS  = 2'd3
    } reg_addr_e;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_INT_EN_BIT = 1;

endpackage

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: CPU-controlled VGA raster generator with registered sync, blank and coordinates.
// Raises a level frame interrupt when the raster enters vertical blanking.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter logic [9:0] H_ACTIVE = DEF_H_ACTIVE,
    parameter logic [9:0] H_FP     = DEF_H_FP,
    parameter logic [9:0] H_SYNC   = DEF_H_SYNC,
    parameter logic [9:0] H_BP     = DEF_H_BP,
    parameter logic [9:0] V_ACTIVE = DEF_V_ACTIVE,
    parameter logic [9:0] V_FP     = DEF_V_FP,
    parameter logic [9:0] V_SYNC   = DEF_V_SYNC,
    parameter logic [9:0] V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       wren,
    input  logic [1:0] addr,
    input  logic [7:0] from_cpu,
    output logic [7:0] to_cpu,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic       pix_ce,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_int
);

    localparam logic [9:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    logic       r_enable;
    logic       r_int_en;
    logic       r_pix_ce;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_blank;
    logic       r_frame_flag;
    logic [9:0] r_pix_x;
    logic [9:0] r_pix_y;
    logic [7:0] r_to_cpu;

    logic       w_ctrl_wr;
    logic       w_status_wr;
    logic       w_run;
    logic       w_adv;
    logic       w_frame_set;
    logic [9:0] w_next_x;
    logic [9:0] w_next_y;
    logic [7:0] w_rd_data;
    logic       w_unused_data;

    assign w_ctrl_wr     = ce & wren & (addr == CTRL);
    assign w_status_wr   = ce & wren & (addr == STATUS);
    assign w_unused_data = ^from_cpu[7:2];

    // A disabling write idles the raster on its own edge, while an enabling write only
    // takes hold one edge later so the divider restarts with the same phase as after reset.
    assign w_run       = r_enable & ~(w_ctrl_wr & ~from_cpu[CTRL_ENABLE_BIT]);
    assign w_adv       = w_run & r_pix_ce;
    assign w_frame_set = w_adv & (w_next_x == 10'd0) & (w_next_y == V_ACTIVE);

    always_comb begin
        w_next_x = r_pix_x;
        w_next_y = r_pix_y;
        if (w_adv) begin
            if (r_pix_x == H_TOTAL - 10'd1) begin
                w_next_x = 10'd0;
                w_next_y = (r_pix_y == V_TOTAL - 10'd1) ? 10'd0 : r_pix_y + 10'd1;
            end else begin
                w_next_x = r_pix_x + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable <= 1'b1;
            r_int_en <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_enable <= from_cpu[CTRL_ENABLE_BIT];
            r_int_en <= from_cpu[CTRL_INT_EN_BIT];
        end
    end

    // Sync and blank are decoded from the next counter value so they land with the counters.
    always_ff @(posedge clk) begin
        if (rst || !w_run) begin
            r_pix_ce <= 1'b0;
            r_pix_x  <= 10'd0;
            r_pix_y  <= 10'd0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_blank  <= 1'b1;
        end else begin
            r_pix_ce <= ~r_pix_ce;
            r_pix_x  <= w_next_x;
            r_pix_y  <= w_next_y;
            r_hsync  <= ~((w_next_x >= H_SYNC_START) && (w_next_x < H_SYNC_END));
            r_vsync  <= ~((w_next_y >= V_SYNC_START) && (w_next_y < V_SYNC_END));
            r_blank  <= (w_next_x >= H_ACTIVE) || (w_next_y >= V_ACTIVE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_flag <= 1'b0;
        end else if (w_frame_set) begin
            r_frame_flag <= 1'b1;
        end else if (w_status_wr) begin
            r_frame_flag <= 1'b0;
        end
    end

    always_comb begin
        w_rd_data = 8'h00;
        case (addr)
            CTRL:    w_rd_data = {6'b0, r_int_en, r_enable};
            LINE_LO: w_rd_data = r_pix_y[7:0];
            LINE_HI: w_rd_data = {6'b0, r_pix_y[9:8]};
            STATUS:  w_rd_data = {4'b0, r_frame_flag, r_blank, ~r_vsync, ~r_hsync};
            default: w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cpu <= 8'h00;
        end else if (ce) begin
            r_to_cpu <= w_rd_data;
        end
    end

    assign to_cpu    = r_to_cpu;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign blank     = r_blank;
    assign pix_ce    = r_pix_ce;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign frame_int = r_frame_flag & r_int_en;

endmodule
